// File: rtl/conv_pkg.sv
// Shared width helpers and default types for the window convolution engine.
//  prod_w : width of one signed pixel*coefficient product
//  acc_w  : width of the sum of all taps (sized so it can never overflow)
//  coef_t / acc_t : coefficient and accumulator types at the default geometry
package conv_pkg;

   localparam int PIXEL_WIDTH_DEF = 8;
   localparam int COEF_WIDTH_DEF  = 8;
   localparam int NTAPS_DEF       = 9;

   // Pixel is zero-extended by one bit to become signed, hence the +1.
   function automatic int prod_w(input int pixel_w, input int coef_w);
      return pixel_w + coef_w + 1;
   endfunction

   function automatic int acc_w(input int pixel_w, input int coef_w, input int ntaps);
      return prod_w(pixel_w, coef_w) + $clog2(ntaps);
   endfunction

   typedef logic signed [COEF_WIDTH_DEF-1:0] coef_t;
   typedef logic signed [acc_w(PIXEL_WIDTH_DEF, COEF_WIDTH_DEF, NTAPS_DEF)-1:0] acc_t;

endpackage

// File: rtl/conv_adder_tree.sv
// Combinational sum of NTAPS signed products.
//  prod : NTAPS packed signed products, PROD_W bits each
//  sum  : signed ACC_W-bit total (ACC_W leaves headroom for every tap)
module conv_adder_tree #(
   parameter int NTAPS  = 9,
   parameter int PROD_W = 17,
   parameter int ACC_W  = 21
) (
   input  logic [NTAPS-1:0][PROD_W-1:0] prod,
   output logic signed [ACC_W-1:0]      sum
);

   // Written as a chain; synthesis rebalances it into a tree.
   always_comb begin
      sum = '0;
      for (int i = 0; i < NTAPS; i++) begin
         sum = sum + ACC_W'($signed(prod[i]));
      end
   end

endmodule

// File: rtl/window_conv_engine.sv
// WINDOW x WINDOW convolution engine with runtime-writable coefficients.
// Pipeline: S1 products, S2 tap sum, S3 shift/ReLU/saturate, then output register.
// Accepted beat at edge N presents its result at edge N+3.
//  clk, rst_n              : clock, async active-low reset
//  win_valid/window/win_ready : input window stream (window[r][c], row-major)
//  coef_we/coef_addr/coef_data: coefficient write port, tap index r*WINDOW+c
//  out_valid/out_pixel/out_ready : result stream
module window_conv_engine
   import conv_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int WINDOW      = 3,
   parameter int COEF_WIDTH  = 8,
   parameter int SHIFT       = 0,
   parameter int OUT_WIDTH   = 8,
   localparam int NTAPS      = WINDOW * WINDOW,
   localparam int AW         = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
   input  logic                                           clk,
   input  logic                                           rst_n,
   input  logic                                           win_valid,
   input  logic [WINDOW-1:0][WINDOW-1:0][PIXEL_WIDTH-1:0] window,
   output logic                                           win_ready,
   input  logic                                           coef_we,
   input  logic [AW-1:0]                                  coef_addr,
   input  logic [COEF_WIDTH-1:0]                          coef_data,
   output logic                                           out_valid,
   output logic [OUT_WIDTH-1:0]                           out_pixel,
   input  logic                                           out_ready
);

   localparam int PROD_W = prod_w(PIXEL_WIDTH, COEF_WIDTH);
   localparam int ACC_W  = acc_w(PIXEL_WIDTH, COEF_WIDTH, NTAPS);
   localparam int STAGES = 3;
   localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

   logic                                adv;
   logic [NTAPS-1:0][COEF_WIDTH-1:0]    coef_q, coef_d;
   logic [NTAPS-1:0][PROD_W-1:0]        prod_q, prod_d;
   logic signed [ACC_W-1:0]             tree_sum;
   logic signed [ACC_W-1:0]             sum_q, sum_d;
   logic signed [ACC_W-1:0]             shifted;
   logic [OUT_WIDTH-1:0]                res_q, res_d;
   logic [OUT_WIDTH-1:0]                out_pixel_q, out_pixel_d;
   // [0]=S1, [1]=S2, [2]=S3, [STAGES]=output register
   logic [STAGES:0]                     vld_pipe_q, vld_pipe_d;

   // Whole pipeline moves as one unit; only a stuck output stalls it.
   assign adv       = !vld_pipe_q[STAGES] || out_ready;
   assign win_ready = adv;
   assign out_valid = vld_pipe_q[STAGES];
   assign out_pixel = out_pixel_q;

   // Coefficient writes ignore the stall; a beat accepted on the same edge
   // multiplies with coef_q, i.e. the pre-write value.
   always_comb begin
      coef_d = coef_q;
      if (coef_we && (32'(coef_addr) < NTAPS)) begin
         coef_d[coef_addr] = coef_data;
      end
   end

   // S1: signed products, pixel zero-extended to stay non-negative
   always_comb begin
      prod_d = prod_q;
      if (adv) begin
         for (int r = 0; r < WINDOW; r++) begin
            for (int c = 0; c < WINDOW; c++) begin
               prod_d[r*WINDOW+c] = PROD_W'($signed({1'b0, window[r][c]}))
                                  * PROD_W'($signed(coef_q[r*WINDOW+c]));
            end
         end
      end
   end

   conv_adder_tree #(
      .NTAPS  (NTAPS),
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_tree (
      .prod (prod_q),
      .sum  (tree_sum)
   );

   // S2: tap sum
   assign sum_d = adv ? tree_sum : sum_q;

   // S3: arithmetic shift, then clamp to [0, 2**OUT_WIDTH-1]
   assign shifted = sum_q >>> SHIFT;

   always_comb begin
      res_d = res_q;
      if (adv) begin
         if (shifted[ACC_W-1])       res_d = '0;
         else if (shifted > OUT_MAX) res_d = '1;
         else                        res_d = shifted[OUT_WIDTH-1:0];
      end
   end

   // Output only loads on a real result so bubbles never disturb out_pixel.
   assign out_pixel_d = (adv && vld_pipe_q[STAGES-1]) ? res_q : out_pixel_q;
   assign vld_pipe_d  = adv ? {vld_pipe_q[STAGES-1:0], win_valid} : vld_pipe_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coef_q      <= '0;
         prod_q      <= '0;
         sum_q       <= '0;
         res_q       <= '0;
         out_pixel_q <= '0;
         vld_pipe_q  <= '0;
      end else begin
         coef_q      <= coef_d;
         prod_q      <= prod_d;
         sum_q       <= sum_d;
         res_q       <= res_d;
         out_pixel_q <= out_pixel_d;
         vld_pipe_q  <= vld_pipe_d;
      end
   end

endmodule

// File: tb/tb_window_conv_engine.sv
// Self-checking bench: two engines (SHIFT=0 and SHIFT=12) share all inputs;
// a reference model pushes expected results at accept time, a monitor pops them on retire.
module tb_window_conv_engine;

   localparam int W  = 3;
   localparam int NT = W * W;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     win_valid = 1'b0;
   logic [W-1:0][W-1:0][7:0] window = '0;
   logic                     coef_we = 1'b0;
   logic [3:0]               coef_addr = '0;
   logic [7:0]               coef_data = '0;
   logic                     out_ready = 1'b1;
   logic                     win_ready, out_valid;
   logic [7:0]               out_pixel;
   logic                     win_ready2, out_valid2;
   logic [7:0]               out_pixel2;

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int exp2_q[$];
   int mcoef[NT];
   int pix[NT];

   always #5 clk = ~clk;

   window_conv_engine #(.PIXEL_WIDTH(8), .WINDOW(3), .COEF_WIDTH(8), .SHIFT(0), .OUT_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .window(window), .win_ready(win_ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid), .out_pixel(out_pixel), .out_ready(out_ready));

   window_conv_engine #(.PIXEL_WIDTH(8), .WINDOW(3), .COEF_WIDTH(8), .SHIFT(12), .OUT_WIDTH(8)) dut_sh (
      .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .window(window), .win_ready(win_ready2),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid2), .out_pixel(out_pixel2), .out_ready(out_ready));

   function automatic int model(input int sh);
      int s = 0;
      for (int i = 0; i < NT; i++) s += mcoef[i] * pix[i];
      s = s >>> sh;
      if (s < 0) return 0;
      if (s > 255) return 255;
      return s;
   endfunction

   // Scoreboard monitor
   always @(negedge clk) begin
      int e;
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_shift0: unexpected output %0d", out_pixel);
         end else begin
            e = exp_q.pop_front();
            if (out_pixel !== 8'(e)) begin
               errors++;
               $display("FAIL out_shift0: got %0d expected %0d", out_pixel, e);
            end
         end
      end
      if (rst_n && out_valid2 && out_ready) begin
         checks++;
         if (exp2_q.size() == 0) begin
            errors++;
            $display("FAIL out_shift12: unexpected output %0d", out_pixel2);
         end else begin
            e = exp2_q.pop_front();
            if (out_pixel2 !== 8'(e)) begin
               errors++;
               $display("FAIL out_shift12: got %0d expected %0d", out_pixel2, e);
            end
         end
      end
   end

   task automatic set_pix(input int all, input int centre);
      for (int i = 0; i < NT; i++) pix[i] = all;
      pix[4] = centre;
   endtask

   task automatic write_coef(input int addr, input int data);
      @(negedge clk);
      coef_we = 1'b1; coef_addr = 4'(addr); coef_data = 8'(data);
      if (addr < NT) mcoef[addr] = data;
      @(posedge clk); #1;
      coef_we = 1'b0;
   endtask

   task automatic set_all_coefs(input int data);
      for (int i = 0; i < NT; i++) write_coef(i, data);
   endtask

   // Presents pix, waits (bounded) for win_ready, records the expectation with
   // the coefficients in effect before any same-edge write.
   task automatic drive_beat(input bit we, input int addr, input int data);
      int n = 0;
      @(negedge clk);
      win_valid = 1'b1;
      for (int i = 0; i < NT; i++) window[i/W][i%W] = 8'(pix[i]);
      coef_we = we; coef_addr = 4'(addr); coef_data = 8'(data);
      while (!win_ready && n < 50) begin @(negedge clk); n++; end
      if (!win_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: win_ready=%0b required 1", win_ready);
      end else begin
         exp_q.push_back(model(0));
         exp2_q.push_back(model(12));
         if (we && addr < NT) mcoef[addr] = data;
      end
      @(posedge clk); #1;
      win_valid = 1'b0;
      coef_we = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || exp2_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: pending=%0d/%0d required 0", name, exp_q.size(), exp2_q.size());
      end
   endtask

   task automatic test_reset();
      #1;
      checks += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
      if (out_pixel !== 8'd0) begin errors++; $display("FAIL reset_out_pixel: got %0d required 0", out_pixel); end
      if (win_ready !== 1'b1) begin errors++; $display("FAIL reset_win_ready: got %0b required 1", win_ready); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      int lat = 0;
      set_all_coefs(1);
      set_pix(10, 10);
      drive_beat(1'b0, 0, 0);
      while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat != 3) begin errors++; $display("FAIL latency: got %0d cycles required 3", lat); end
      wait_drain("basic");
   endtask

   task automatic test_relu();
      set_all_coefs(-1);
      set_pix(10, 10);
      drive_beat(1'b0, 0, 0);
      wait_drain("relu");
   endtask

   task automatic test_saturate();
      set_all_coefs(127);
      set_pix(255, 255);
      drive_beat(1'b0, 0, 0);
      wait_drain("saturate");
   endtask

   task automatic test_back_to_back_stall();
      set_all_coefs(0);
      write_coef(4, 1);
      fork
         begin
            for (int k = 1; k <= 6; k++) begin
               set_pix(0, k);
               drive_beat(1'b0, 0, 0);
            end
         end
         begin
            int n = 0;
            while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
            out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(posedge clk); #1;
               checks++;
               if (win_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_win_ready: cycle %0d got %0b required 0", s, win_ready);
               end
            end
            out_ready = 1'b1;
         end
      join
      wait_drain("stream");
   endtask

   task automatic test_coef_same_edge();
      set_pix(0, 7);
      drive_beat(1'b1, 4, 2);
      drive_beat(1'b0, 0, 0);
      write_coef(9, 100);
      set_pix(1, 7);
      drive_beat(1'b0, 0, 0);
      wait_drain("coef_edge");
   endtask

   task automatic test_reset_inflight();
      set_pix(10, 10);
      for (int k = 0; k < 3; k++) drive_beat(1'b0, 0, 0);
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %0b required 0", out_valid); end
      if (out_pixel !== 8'd0) begin errors++; $display("FAIL midreset_out_pixel: got %0d required 0", out_pixel); end
      if (win_ready !== 1'b1) begin errors++; $display("FAIL midreset_win_ready: got %0b required 1", win_ready); end
      exp_q.delete();
      exp2_q.delete();
      for (int i = 0; i < NT; i++) mcoef[i] = 0;
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_output: got %0b required 0", out_valid); end
      set_pix(10, 10);
      drive_beat(1'b0, 0, 0);
      wait_drain("after_reset");
      write_coef(4, 1);
      set_pix(3, 5);
      drive_beat(1'b0, 0, 0);
      wait_drain("rewrite");
   endtask

   initial begin
      for (int i = 0; i < NT; i++) begin mcoef[i] = 0; pix[i] = 0; end
      test_reset();
      test_basic();
      test_relu();
      test_saturate();
      test_back_to_back_stall();
      test_coef_same_edge();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
